// File: rtl/gigatron_input_arbiter.sv
// Gigatron Famicom-port input arbiter: queued ASCII keys win over the
// joystick, each key held for HOLD_FRAMES latches then GAP_FRAMES of 0xFF.
// Ports: clk_sys/reset; famicom_latch/pulse in, famicom_data out (LSB first);
// joy_buttons; kbd_valid/kbd_data/kbd_ready push; kbd_flush; fifo_level; busy.
module gigatron_input_arbiter #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 2
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        famicom_latch,
    input  logic                        famicom_pulse,
    output logic                        famicom_data,
    input  logic [7:0]                  joy_buttons,
    input  logic                        kbd_valid,
    input  logic [7:0]                  kbd_data,
    output logic                        kbd_ready,
    input  logic                        kbd_flush,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXF = (HOLD_FRAMES > GAP_FRAMES) ?
                          HOLD_FRAMES : GAP_FRAMES;
    localparam int CW   = $clog2(MAXF) + 1;

    typedef enum logic [1:0] {
        S_JOY,
        S_HOLD,
        S_GAP
    } state_t;

    logic          r_latch_s1, r_latch_s2, r_latch_s3;
    logic          r_pulse_s1, r_pulse_s2, r_pulse_s3;
    logic [7:0]    r_sr;
    logic [7:0]    r_cur;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic          r_busy;

    logic          w_latch_rise, w_pulse_rise;
    logic          w_push, w_pop;
    logic [7:0]    w_head;
    logic [7:0]    w_frame;

    assign w_latch_rise = r_latch_s2 & ~r_latch_s3;
    assign w_pulse_rise = r_pulse_s2 & ~r_pulse_s3;

    assign kbd_ready  = (r_level != LW'(FIFO_DEPTH));
    assign fifo_level = r_level;
    assign busy       = r_busy;
    assign famicom_data = r_sr[0];

    assign w_head = r_mem[r_rd_ptr];
    assign w_push = kbd_valid & kbd_ready & ~kbd_flush;
    // Uses the registered level, so a byte pushed this cycle is not
    // visible to a pop until the next cycle.
    assign w_pop  = w_latch_rise & (r_state == S_JOY) &
                    (r_level != '0) & ~kbd_flush;

    always_comb begin
        w_frame = 8'hFF;
        unique case (r_state)
            S_JOY:   w_frame = w_pop ? w_head : ~joy_buttons;
            S_HOLD:  w_frame = r_cur;
            S_GAP:   w_frame = 8'hFF;
            default: w_frame = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_latch_s1 <= 1'b0;
            r_latch_s2 <= 1'b0;
            r_latch_s3 <= 1'b0;
            r_pulse_s1 <= 1'b0;
            r_pulse_s2 <= 1'b0;
            r_pulse_s3 <= 1'b0;
        end else begin
            r_latch_s1 <= famicom_latch;
            r_latch_s2 <= r_latch_s1;
            r_latch_s3 <= r_latch_s2;
            r_pulse_s1 <= famicom_pulse;
            r_pulse_s2 <= r_pulse_s1;
            r_pulse_s3 <= r_pulse_s2;
        end
    end

    // Load beats shift when both edges land in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sr <= 8'hFF;
        end else if (w_latch_rise) begin
            r_sr <= w_frame;
        end else if (w_pulse_rise && !r_latch_s2) begin
            r_sr <= {1'b1, r_sr[7:1]};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= kbd_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || kbd_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
        end
    end

    // r_cnt counts frames already presented in the current key phase.
    always_ff @(posedge clk_sys) begin
        if (reset || kbd_flush) begin
            r_state <= S_JOY;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (reset) r_cur <= 8'h00;
        end else if (w_latch_rise) begin
            unique case (r_state)
                S_JOY: begin
                    if (w_pop) begin
                        r_cur  <= w_head;
                        r_busy <= 1'b1;
                        if (HOLD_FRAMES == 1) begin
                            r_state <= S_GAP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CW'(HOLD_FRAMES - 1)) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == CW'(GAP_FRAMES - 1)) begin
                        r_state <= S_JOY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_JOY;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// Directed bench for gigatron_input_arbiter: joystick frames, key hold/gap,
// queue back-pressure, flush, load-vs-shift priority and mid-key reset.
module tb_gigatron_input_arbiter;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       famicom_latch;
    logic       famicom_pulse;
    logic       famicom_data;
    logic [7:0] joy_buttons;
    logic       kbd_valid;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_flush;
    logic [4:0] fifo_level;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    gigatron_input_arbiter #(
        .FIFO_DEPTH (16),
        .HOLD_FRAMES(2),
        .GAP_FRAMES (2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .famicom_latch(famicom_latch),
        .famicom_pulse(famicom_pulse),
        .famicom_data (famicom_data),
        .joy_buttons  (joy_buttons),
        .kbd_valid    (kbd_valid),
        .kbd_data     (kbd_data),
        .kbd_ready    (kbd_ready),
        .kbd_flush    (kbd_flush),
        .fifo_level   (fifo_level),
        .busy         (busy)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_latch();
        famicom_latch = 1'b1;
        tick(4);
        famicom_latch = 1'b0;
        tick(4);
    endtask

    task automatic do_pulse();
        famicom_pulse = 1'b1;
        tick(4);
        famicom_pulse = 1'b0;
        tick(4);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            b[i] = famicom_data;
            do_pulse();
        end
    endtask

    task automatic frame(output logic [7:0] b);
        do_latch();
        read_byte(b);
    endtask

    task automatic push(input logic [7:0] d);
        kbd_data  = d;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] exp1 [5];
        logic [7:0] kexp;
        exp1 = '{8'h41, 8'h41, 8'hFF, 8'hFF, 8'hFF};

        reset         = 1'b1;
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        joy_buttons   = 8'h00;
        kbd_valid     = 1'b0;
        kbd_data      = 8'h00;
        kbd_flush     = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();

        chk("rst_data", {7'd0, famicom_data}, 8'h01);
        chk("rst_level", {3'd0, fifo_level}, 8'h00);
        chk("rst_ready", {7'd0, kbd_ready}, 8'h01);
        chk("rst_busy", {7'd0, busy}, 8'h00);

        joy_buttons   = 8'h81;
        famicom_latch = 1'b1;
        tick(2);
        chk("lat_2cyc", {7'd0, famicom_data}, 8'h01);
        tick();
        chk("lat_3cyc", {7'd0, famicom_data}, 8'h00);
        tick();
        famicom_latch = 1'b0;
        tick(4);
        read_byte(b);
        chk("joy_81", b, 8'h7E);
        do_pulse();
        chk("joy_extra", {7'd0, famicom_data}, 8'h01);

        joy_buttons = 8'h00;
        push(8'h41);
        chk("key_level", {3'd0, fifo_level}, 8'h01);
        for (int f = 0; f < 5; f++) begin
            frame(b);
            chk($sformatf("key_f%0d", f), b, exp1[f]);
            if (f == 0) chk("key_busy1", {7'd0, busy}, 8'h01);
            if (f == 2) chk("key_busy3", {7'd0, busy}, 8'h01);
            if (f == 3) chk("key_busy4", {7'd0, busy}, 8'h00);
        end

        for (int i = 0; i < 17; i++) begin
            kbd_data  = 8'(8'h30 + i);
            kbd_valid = 1'b1;
            if (i == 15) chk("full_rdy15", {7'd0, kbd_ready}, 8'h01);
            if (i == 16) chk("full_rdy16", {7'd0, kbd_ready}, 8'h00);
            tick();
        end
        kbd_valid = 1'b0;
        chk("full_level", {3'd0, fifo_level}, 8'h10);
        chk("full_ready", {7'd0, kbd_ready}, 8'h00);
        for (int k = 0; k < 16; k++) begin
            kexp = 8'(8'h30 + k);
            for (int f = 0; f < 4; f++) begin
                frame(b);
                chk($sformatf("q_k%0d_f%0d", k, f), b,
                    (f < 2) ? kexp : 8'hFF);
            end
        end
        chk("q_empty", {3'd0, fifo_level}, 8'h00);
        chk("q_idle", {7'd0, busy}, 8'h00);

        joy_buttons = 8'h12;
        push(8'h61);
        push(8'h62);
        frame(b);
        chk("fl_key", b, 8'h61);
        chk("fl_busy_pre", {7'd0, busy}, 8'h01);
        chk("fl_level_pre", {3'd0, fifo_level}, 8'h01);
        kbd_flush = 1'b1;
        tick();
        kbd_flush = 1'b0;
        chk("fl_level", {3'd0, fifo_level}, 8'h00);
        chk("fl_busy", {7'd0, busy}, 8'h00);
        frame(b);
        chk("fl_joy", b, 8'hED);

        joy_buttons = 8'hA5;
        do_latch();
        chk("sim_pre", {7'd0, famicom_data}, 8'h00);
        joy_buttons   = 8'h3C;
        famicom_latch = 1'b1;
        famicom_pulse = 1'b1;
        tick(4);
        famicom_latch = 1'b0;
        tick(4);
        famicom_pulse = 1'b0;
        tick(4);
        read_byte(b);
        chk("sim_load", b, 8'hC3);

        joy_buttons = 8'h00;
        push(8'h42);
        push(8'h43);
        do_latch();
        chk("rk_data_pre", {7'd0, famicom_data}, 8'h00);
        chk("rk_busy_pre", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rk_data", {7'd0, famicom_data}, 8'h01);
        chk("rk_level", {3'd0, fifo_level}, 8'h00);
        chk("rk_ready", {7'd0, kbd_ready}, 8'h01);
        chk("rk_busy", {7'd0, busy}, 8'h00);
        joy_buttons = 8'h22;
        frame(b);
        chk("rk_joy", b, 8'hDD);
        chk("rk_busy_post", {7'd0, busy}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
